// File: rtl/riscv_writeback.sv
// Writeback stage: owns the regfile write port, merges ALU results with in-order load returns.
// Latency: ALU result 1 cycle; load response >=1 cycle, +1 per cycle held off by the ALU.
// Backpressure: issue stalls on full rd FIFO or pending rd; responses stall on full buffer.
module riscv_writeback_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

module riscv_writeback #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int NUM_REGS    = 32,
    parameter int LOAD_DEPTH  = 4,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [ADDR_LENGTH-1:0] alu_rd,
    input  logic [WORD_LENGTH-1:0] alu_data,
    input  logic                   load_issue_valid,
    input  logic [ADDR_LENGTH-1:0] load_issue_rd,
    output logic                   load_issue_ready,
    input  logic                   load_resp_valid,
    input  logic [WORD_LENGTH-1:0] load_resp_data,
    output logic                   load_resp_ready,
    input  logic [ADDR_LENGTH-1:0] rs1_addr,
    input  logic [ADDR_LENGTH-1:0] rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   write_en,
    output logic [ADDR_LENGTH-1:0] write_addr,
    output logic [WORD_LENGTH-1:0] data,
    output logic                   idle
);
    localparam int RD_CW  = $clog2(LOAD_DEPTH + 1);
    localparam int BUF_CW = $clog2(RESP_DEPTH + 1);

    logic [NUM_REGS-1:0]    pending_q;
    logic [NUM_REGS-1:0]    pending_n;
    logic [ADDR_LENGTH-1:0] rd_head;
    logic                   rd_full, rd_empty, rd_pop;
    logic [RD_CW-1:0]       rd_count;
    logic [WORD_LENGTH-1:0] buf_head;
    logic                   buf_full, buf_empty, buf_pop, buf_push;
    logic [BUF_CW-1:0]      buf_count;
    logic                   issue, resp_acc;
    logic                   sel_vld;
    logic [ADDR_LENGTH-1:0] sel_rd;
    logic [WORD_LENGTH-1:0] sel_dat;

    assign load_issue_ready = !rd_full && !pending_q[load_issue_rd];
    assign load_resp_ready  = !buf_full;
    assign issue            = load_issue_valid && load_issue_ready;
    // A response is only meaningful if some issued load has no data yet; strays are dropped.
    assign resp_acc         = load_resp_valid && load_resp_ready && (32'(rd_count) > 32'(buf_count));
    assign idle             = rd_empty && buf_empty;

    assign rs1_busy = pending_q[rs1_addr] || (issue && load_issue_rd == rs1_addr && rs1_addr != '0);
    assign rs2_busy = pending_q[rs2_addr] || (issue && load_issue_rd == rs2_addr && rs2_addr != '0);

    riscv_writeback_fifo #(.WIDTH(ADDR_LENGTH), .DEPTH(LOAD_DEPTH)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n), .push(issue), .push_dat(load_issue_rd), .pop(rd_pop),
        .head_dat(rd_head), .full(rd_full), .empty(rd_empty), .count(rd_count)
    );

    riscv_writeback_fifo #(.WIDTH(WORD_LENGTH), .DEPTH(RESP_DEPTH)) u_resp_buf (
        .clk(clk), .rst_n(rst_n), .push(buf_push), .push_dat(load_resp_data), .pop(buf_pop),
        .head_dat(buf_head), .full(buf_full), .empty(buf_empty), .count(buf_count)
    );

    // ALU owns the port; buffered load data drains before a fresh response may bypass.
    always_comb begin
        sel_vld  = 1'b0;
        sel_rd   = '0;
        sel_dat  = '0;
        rd_pop   = 1'b0;
        buf_pop  = 1'b0;
        buf_push = 1'b0;
        if (alu_valid) begin
            sel_vld  = 1'b1;
            sel_rd   = alu_rd;
            sel_dat  = alu_data;
            buf_push = resp_acc;
        end else if (!buf_empty) begin
            sel_vld  = 1'b1;
            sel_rd   = rd_head;
            sel_dat  = buf_head;
            rd_pop   = 1'b1;
            buf_pop  = 1'b1;
            buf_push = resp_acc;
        end else if (resp_acc) begin
            sel_vld  = 1'b1;
            sel_rd   = rd_head;
            sel_dat  = load_resp_data;
            rd_pop   = 1'b1;
        end
    end

    always_comb begin
        pending_n = pending_q;
        if (rd_pop) pending_n[rd_head] = 1'b0;
        if (issue && load_issue_rd != '0) pending_n[load_issue_rd] = 1'b1;
        pending_n[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            write_addr <= '0;
            data       <= '0;
            pending_q  <= '0;
        end else begin
            write_en  <= sel_vld && (sel_rd != '0);
            if (sel_vld) begin
                write_addr <= sel_rd;
                data       <= sel_dat;
            end
            pending_q <= pending_n;
        end
    end
endmodule

// File: tb/tb_riscv_writeback.sv
// Bench for riscv_writeback: directed scenarios plus randomized traffic against a queue-based model.
module tb_riscv_writeback;
    localparam int LD = 4;
    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        load_issue_valid = 1'b0;
    logic [4:0]  load_issue_rd = '0;
    logic        load_issue_ready;
    logic        load_resp_valid = 1'b0;
    logic [31:0] load_resp_data = '0;
    logic        load_resp_ready;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy, rs2_busy;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] data;
    logic        idle;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_issue_valid(load_issue_valid), .load_issue_rd(load_issue_rd),
        .load_issue_ready(load_issue_ready),
        .load_resp_valid(load_resp_valid), .load_resp_data(load_resp_data),
        .load_resp_ready(load_resp_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .write_en(write_en), .write_addr(write_addr), .data(data), .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference model: destinations of loads still owed a commit, and data that arrived but waits.
    logic [4:0]  mq_rd[$];
    logic [31:0] mq_dat[$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_wa = '0;
    logic [31:0] exp_wd = '0;

    function automatic bit m_pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq_rd[i]) if (mq_rd[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_issue_ready();
        return (mq_rd.size() < LD) && !m_pending(load_issue_rd);
    endfunction

    function automatic bit m_resp_ready();
        return mq_dat.size() < RD;
    endfunction

    function automatic bit m_busy(input logic [4:0] r);
        return m_pending(r) || (load_issue_valid && m_issue_ready() && r != 5'd0 && load_issue_rd == r);
    endfunction

    function automatic bit m_idle();
        return (mq_rd.size() == 0) && (mq_dat.size() == 0);
    endfunction

    task automatic m_reset();
        mq_rd.delete();
        mq_dat.delete();
        exp_we = 1'b0;
    endtask

    task automatic m_commit(input logic [4:0] r, input logic [31:0] d);
        exp_we = (r != 5'd0);
        if (r != 5'd0) begin
            exp_wa = r;
            exp_wd = d;
        end
    endtask

    // Applies one clock of the write-port rules to the model, then advances the DUT.
    task automatic tick();
        bit iss, acc;
        logic [4:0]  r;
        logic [31:0] d;
        iss = load_issue_valid && m_issue_ready();
        acc = load_resp_valid && m_resp_ready() && (mq_rd.size() > mq_dat.size());
        exp_we = 1'b0;
        if (alu_valid) begin
            m_commit(alu_rd, alu_data);
            if (acc) mq_dat.push_back(load_resp_data);
        end else if (mq_dat.size() > 0) begin
            r = mq_rd.pop_front();
            d = mq_dat.pop_front();
            m_commit(r, d);
            if (acc) mq_dat.push_back(load_resp_data);
        end else if (acc) begin
            r = mq_rd.pop_front();
            m_commit(r, load_resp_data);
        end
        if (iss) mq_rd.push_back(load_issue_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        alu_valid        = 1'b0;
        load_issue_valid = 1'b0;
        load_resp_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (write_en !== 1'b0 || write_addr !== 5'd0 || data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_write got en=%b addr=%0d data=%h exp 0/0/0", write_en, write_addr, data);
        end
        n_tests++;
        if (load_issue_ready !== 1'b1 || load_resp_ready !== 1'b1 || idle !== 1'b1 ||
            rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status got ir=%b rr=%b idle=%b b1=%b b2=%b exp 1/1/1/0/0",
                     load_issue_ready, load_resp_ready, idle, rs1_busy, rs2_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1; tick();
        n_tests++;
        if (write_en !== 1'b1 || write_addr !== 5'd5 || data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alu_write got en=%b addr=%0d data=%h exp 1/5/deadbeef", write_en, write_addr, data);
        end
        alu_rd = 5'd0; alu_data = 32'h12345678;
        #1; tick();
        n_tests++;
        if (write_en !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_x0 got en=%b exp 0", write_en);
        end
        quiet_inputs();
        #1; tick();
    endtask

    task automatic test_load_round_trip();
        rs1_addr = 5'd7;
        load_issue_valid = 1'b1; load_issue_rd = 5'd7;
        #1;
        n_tests++;
        if (load_issue_ready !== 1'b1 || rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_issue got ready=%b busy=%b exp 1/1", load_issue_ready, rs1_busy);
        end
        tick();
        quiet_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (rs1_busy !== 1'b1 || idle !== 1'b0) begin
                n_fail++;
                $display("FAIL rt_pending cyc %0d got busy=%b idle=%b exp 1/0", i, rs1_busy, idle);
            end
            tick();
        end
        load_resp_valid = 1'b1; load_resp_data = 32'h1234;
        #1;
        n_tests++;
        if (rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_busy_at_commit got %b exp 1", rs1_busy);
        end
        tick();
        quiet_inputs();
        #1;
        n_tests++;
        if (write_en !== 1'b1 || write_addr !== 5'd7 || data !== 32'h1234 || rs1_busy !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rt_commit got en=%b addr=%0d data=%h busy=%b idle=%b exp 1/7/1234/0/1",
                     write_en, write_addr, data, rs1_busy, idle);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [4:0]  exp_a[5] = '{5'd10, 5'd11, 5'd12, 5'd3, 5'd4};
        logic [31:0] exp_d[5] = '{32'hA0, 32'hA1, 32'hA2, 32'hC3, 32'hC4};
        load_issue_valid = 1'b1; load_issue_rd = 5'd3; #1; tick();
        load_issue_rd = 5'd4; #1; tick();
        load_issue_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            alu_valid = (c < 3);
            alu_rd = 5'(10 + c);
            alu_data = 32'(32'hA0 + c);
            load_resp_valid = (c < 2);
            load_resp_data = (c == 0) ? 32'hC3 : 32'hC4;
            #1;
            if (c == 2) begin
                n_tests++;
                if (load_resp_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cont_buf_full got resp_ready=%b exp 0", load_resp_ready);
                end
            end
            tick();
            n_tests++;
            if (write_en !== 1'b1 || write_addr !== exp_a[c] || data !== exp_d[c]) begin
                n_fail++;
                $display("FAIL cont_write %0d got en=%b addr=%0d data=%h exp 1/%0d/%h",
                         c, write_en, write_addr, data, exp_a[c], exp_d[c]);
            end
        end
        quiet_inputs();
        #1; tick();
        n_tests++;
        if (write_en !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_drained got en=%b idle=%b exp 0/1", write_en, idle);
        end
    endtask

    task automatic test_issue_backpressure();
        for (int i = 1; i <= 4; i++) begin
            load_issue_valid = 1'b1; load_issue_rd = 5'(i);
            #1;
            n_tests++;
            if (load_issue_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_fill rd %0d got ready=%b exp 1", i, load_issue_ready);
            end
            tick();
        end
        load_issue_valid = 1'b0; load_issue_rd = 5'd5;
        #1;
        n_tests++;
        if (load_issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full got ready=%b exp 0", load_issue_ready);
        end
        load_resp_valid = 1'b1; load_resp_data = 32'h100;
        #1;
        n_tests++;
        if (load_issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_at_commit got ready=%b exp 0", load_issue_ready);
        end
        tick();
        load_resp_valid = 1'b0;
        #1;
        n_tests++;
        if (write_en !== 1'b1 || write_addr !== 5'd1 || data !== 32'h100 || load_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release got en=%b addr=%0d data=%h ready=%b exp 1/1/100/1",
                     write_en, write_addr, data, load_issue_ready);
        end
        load_issue_rd = 5'd2;
        #1;
        n_tests++;
        if (load_issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_same_rd got ready=%b exp 0", load_issue_ready);
        end
        load_issue_rd = 5'd0;
        #1;
        n_tests++;
        if (load_issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_x0 got ready=%b exp 1", load_issue_ready);
        end
        for (int i = 2; i <= 4; i++) begin
            load_resp_valid = 1'b1; load_resp_data = 32'(i * 32'h100);
            #1; tick();
            n_tests++;
            if (write_en !== exp_we || write_addr !== exp_wa || data !== exp_wd || write_addr !== 5'(i)) begin
                n_fail++;
                $display("FAIL bp_drain rd %0d got en=%b addr=%0d data=%h exp %b/%0d/%h",
                         i, write_en, write_addr, data, exp_we, exp_wa, exp_wd);
            end
        end
        quiet_inputs();
        #1; tick();
    endtask

    task automatic test_back_to_back_wrap();
        for (int k = 0; k <= 10; k++) begin
            load_issue_valid = (k < 10);
            load_issue_rd = 5'(k + 1);
            load_resp_valid = (k > 0);
            load_resp_data = 32'(k) * 32'h01010101;
            #1;
            if (k < 10) begin
                n_tests++;
                if (load_issue_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_ready k %0d got %b exp 1", k, load_issue_ready);
                end
            end
            tick();
            if (k > 0) begin
                n_tests++;
                if (write_en !== 1'b1 || write_addr !== 5'(k) || data !== 32'(k) * 32'h01010101) begin
                    n_fail++;
                    $display("FAIL wrap_write k %0d got en=%b addr=%0d data=%h", k, write_en, write_addr, data);
                end
            end
        end
        quiet_inputs();
        load_resp_valid = 1'b1; load_resp_data = 32'hBAD;
        #1; tick();
        load_resp_valid = 1'b0;
        #1;
        n_tests++;
        if (write_en !== 1'b0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_stray_resp got en=%b idle=%b exp 0/1", write_en, idle);
        end
    endtask

    task automatic test_async_reset();
        rs1_addr = 5'd8; rs2_addr = 5'd9;
        load_issue_valid = 1'b1; load_issue_rd = 5'd8; #1; tick();
        load_issue_rd = 5'd9; #1; tick();
        load_issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h55;
        load_resp_valid = 1'b1; load_resp_data = 32'h88;
        #1; tick();
        quiet_inputs();
        n_tests++;
        if (write_en !== 1'b1 || idle !== 1'b0 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_before got en=%b idle=%b b1=%b b2=%b exp 1/0/1/1", write_en, idle, rs1_busy, rs2_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (write_en !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || idle !== 1'b1 ||
            load_issue_ready !== 1'b1 || load_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_during got en=%b b1=%b b2=%b idle=%b ir=%b rr=%b exp 0/0/0/1/1/1",
                     write_en, rs1_busy, rs2_busy, idle, load_issue_ready, load_resp_ready);
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        #1; tick();
        alu_valid = 1'b0;
        n_tests++;
        if (write_en !== 1'b1 || write_addr !== 5'd6 || data !== 32'h66 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_after got en=%b addr=%0d data=%h idle=%b exp 1/6/66/1", write_en, write_addr, data, idle);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            alu_valid        = ($urandom_range(0, 2) == 0);
            alu_rd           = 5'($urandom_range(0, 7));
            alu_data         = $urandom;
            load_issue_valid = ($urandom_range(0, 1) == 0);
            load_issue_rd    = 5'($urandom_range(0, 7));
            load_resp_valid  = ($urandom_range(0, 2) != 0);
            load_resp_data   = $urandom;
            rs1_addr         = 5'($urandom_range(0, 7));
            rs2_addr         = 5'($urandom_range(0, 7));
            #1;
            n_tests++;
            if (load_issue_ready !== m_issue_ready() || load_resp_ready !== m_resp_ready() ||
                rs1_busy !== m_busy(rs1_addr) || rs2_busy !== m_busy(rs2_addr) || idle !== m_idle()) begin
                n_fail++;
                $display("FAIL rnd_status cyc %0d got ir=%b rr=%b b1=%b b2=%b idle=%b exp %b/%b/%b/%b/%b",
                         c, load_issue_ready, load_resp_ready, rs1_busy, rs2_busy, idle,
                         m_issue_ready(), m_resp_ready(), m_busy(rs1_addr), m_busy(rs2_addr), m_idle());
            end
            tick();
            n_tests++;
            if (write_en !== exp_we || (exp_we && (write_addr !== exp_wa || data !== exp_wd))) begin
                n_fail++;
                $display("FAIL rnd_write cyc %0d got en=%b addr=%0d data=%h exp %b/%0d/%h",
                         c, write_en, write_addr, data, exp_we, exp_wa, exp_wd);
            end
        end
        quiet_inputs();
        for (int c = 0; c < 12; c++) begin
            load_resp_valid = 1'b1; load_resp_data = $urandom;
            #1; tick();
        end
        load_resp_valid = 1'b0;
        #1;
        n_tests++;
        if (idle !== 1'b1 || idle !== m_idle()) begin
            n_fail++;
            $display("FAIL rnd_drain got idle=%b exp 1", idle);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_round_trip();
        test_contention();
        test_issue_backpressure();
        test_back_to_back_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
